// File: rtl/btle_le1m_rx.sv
// btle_le1m_rx: Bluetooth LE 1M-PHY baseband receiver.
//
// Takes complex baseband IQ at SAMPLE_PER_SYMBOL samples per bit. Each sample
// is turned into a bit by the sign of the phase difference to the previous
// sample. The access address is searched on every sample phase in parallel.
// After a hit, only the winning phase is decoded. Its bits are dewhitened,
// header and payload octets are written into a 64-octet RAM, and the
// trailing CRC24 is checked.
//
// Ports
//   clk, rst                  clock; synchronous active-high reset
//   unique_bit_sequence       access address, bit 0 is first over the air
//   channel_number            channel index, seeds the dewhitening LFSR
//   crc_state_init_bit        CRC24 preset
//   i, q, iq_valid            signed IQ sample and its strobe (<= 1 per 2 clk)
//   hit_flag                  1-clk pulse on access-address match
//   decode_run                high while PDU and CRC bits are being decoded
//   decode_end                1-clk pulse on the last CRC bit
//   crc_ok                    CRC result, valid from decode_end until next hit
//   best_phase                sample-phase lane that matched
//   payload_length            header octet 1 bits [6:0]
//   pdu_octet_mem_addr/_data  asynchronous RAM read port
//
// Build option
//   BTLE_RX_AA_TOLERANCE_EN   accept the access address with up to one bit error
//
// state  | meaning
// SEARCH | shifting bits into all phase lanes, looking for the access address
// DECODE | dewhitening/capturing PDU bits on best_phase, then checking CRC
module btle_le1m_rx #(
    parameter int SAMPLE_PER_SYMBOL           = 8,
    parameter int GFSK_DEMODULATION_BIT_WIDTH = 16,
    parameter int LEN_UNIQUE_BIT_SEQUENCE     = 32,
    parameter int CHANNEL_NUMBER_BIT_WIDTH    = 6,
    parameter int CRC_STATE_BIT_WIDTH         = 24
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic [LEN_UNIQUE_BIT_SEQUENCE-1:0]           unique_bit_sequence,
    input  logic [CHANNEL_NUMBER_BIT_WIDTH-1:0]          channel_number,
    input  logic [CRC_STATE_BIT_WIDTH-1:0]               crc_state_init_bit,
    input  logic signed [GFSK_DEMODULATION_BIT_WIDTH-1:0] i,
    input  logic signed [GFSK_DEMODULATION_BIT_WIDTH-1:0] q,
    input  logic                                         iq_valid,
    output logic                                         hit_flag,
    output logic                                         decode_run,
    output logic                                         decode_end,
    output logic                                         crc_ok,
    output logic [$clog2(SAMPLE_PER_SYMBOL)-1:0]         best_phase,
    output logic [6:0]                                   payload_length,
    output logic [7:0]                                   pdu_octet_mem_data,
    input  logic [5:0]                                   pdu_octet_mem_addr
);
    localparam int W  = GFSK_DEMODULATION_BIT_WIDTH;
    localparam int L  = LEN_UNIQUE_BIT_SEQUENCE;
    localparam int C  = CRC_STATE_BIT_WIDTH;
    localparam int PW = $clog2(SAMPLE_PER_SYMBOL);
    localparam int WL = CHANNEL_NUMBER_BIT_WIDTH + 1;
    localparam logic [C-1:0] CRC_POLY = C'(24'h00065B);

    typedef enum logic {SEARCH, DECODE} state_t;
    state_t state_q, state_d;

    logic signed [W-1:0]   i_prev_q, q_prev_q;
    logic signed [2*W-1:0] prod_qi, prod_iq;
    logic signed [2*W:0]   diff;
    logic                  demod_bit;
    logic                  bit_q, bit_vld_q;
    logic [PW-1:0]         phase_q, phase_nxt;
    // Lanes keep only the 31 newest bits; the oldest bit is only needed at
    // the moment of comparison, when it is still present in lane_new.
    logic [L-2:0]          lane_q [SAMPLE_PER_SYMBOL];
    logic [L-1:0]          lane_new, aa_diff;
    logic                  aa_match;
    logic                  hit_q, end_q, crc_ok_q, crc_err_q;
    logic [PW-1:0]         best_phase_q;
    logic [WL-1:0]         whiten_q;
    logic [C-1:0]          crc_q, crc_step;
    logic                  crc_fb;
    logic [10:0]           cnt_q, pdu_bits;
    logic [6:0]            oct_q;
    logic [6:0]            len_q;
    logic                  sym_vld, dbit, in_pdu, last_bit, ram_we;
    logic [7:0]            ram_q [64];

    // Im(conj(z_prev) * z): positive for a positive frequency deviation.
    assign prod_qi   = (2*W)'(q) * (2*W)'(i_prev_q);
    assign prod_iq   = (2*W)'(i) * (2*W)'(q_prev_q);
    assign diff      = (2*W+1)'(prod_qi) - (2*W+1)'(prod_iq);
    assign demod_bit = ~diff[2*W] & (|diff);

    assign phase_nxt = (phase_q == PW'(SAMPLE_PER_SYMBOL - 1)) ? '0 : phase_q + 1'b1;
    assign lane_new  = {bit_q, lane_q[phase_q]};
    assign aa_diff   = lane_new ^ unique_bit_sequence;
`ifdef BTLE_RX_AA_TOLERANCE_EN
    // x & (x-1) clears the lowest set bit, so zero means at most one bit set.
    assign aa_match  = ((aa_diff & (aa_diff - L'(1))) == '0);
`else
    assign aa_match  = (aa_diff == '0);
`endif

    assign sym_vld  = (state_q == DECODE) && bit_vld_q && (phase_q == best_phase_q);
    assign dbit     = bit_q ^ whiten_q[0];
    assign pdu_bits = {({1'b0, len_q} + 8'd2), 3'b000};
    assign in_pdu   = (cnt_q < pdu_bits);
    assign last_bit = (cnt_q == pdu_bits + 11'd23);
    assign crc_fb   = crc_q[C-1] ^ dbit;
    assign crc_step = {crc_q[C-2:0], 1'b0} ^ (crc_fb ? CRC_POLY : '0);
    assign ram_we   = !rst && sym_vld && in_pdu && (cnt_q[2:0] == 3'd7) && (cnt_q[10:9] == 2'b00);

    always_ff @(posedge clk) begin
        if (rst) state_q <= SEARCH;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            SEARCH:  if (bit_vld_q && aa_match) state_d = DECODE;
            DECODE:  if (sym_vld && !in_pdu && last_bit) state_d = SEARCH;
            default: state_d = SEARCH;
        endcase
    end

    always_comb begin
        decode_run = (state_q == DECODE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            i_prev_q     <= '0;
            q_prev_q     <= '0;
            bit_q        <= 1'b0;
            bit_vld_q    <= 1'b0;
            phase_q      <= '0;
            hit_q        <= 1'b0;
            end_q        <= 1'b0;
            crc_ok_q     <= 1'b0;
            crc_err_q    <= 1'b0;
            best_phase_q <= '0;
            whiten_q     <= '0;
            crc_q        <= '0;
            cnt_q        <= '0;
            oct_q        <= '0;
            len_q        <= '0;
            for (int k = 0; k < SAMPLE_PER_SYMBOL; k++) lane_q[k] <= '0;
        end else begin
            bit_vld_q <= iq_valid;
            if (iq_valid) begin
                i_prev_q <= i;
                q_prev_q <= q;
                bit_q    <= demod_bit;
            end
            if (bit_vld_q) phase_q <= phase_nxt;
            hit_q <= 1'b0;
            end_q <= 1'b0;

            if (state_q == SEARCH && bit_vld_q) begin
                lane_q[phase_q] <= lane_new[L-1:1];
                if (aa_match) begin
                    hit_q        <= 1'b1;
                    best_phase_q <= phase_q;
                    whiten_q     <= {1'b1, channel_number};
                    crc_q        <= crc_state_init_bit;
                    crc_err_q    <= 1'b0;
                    crc_ok_q     <= 1'b0;
                    cnt_q        <= '0;
                    len_q        <= '0;
                end
            end

            if (sym_vld) begin
                // x^7+x^4+1 whitening, output taken from the LSB.
                whiten_q <= {whiten_q[0], whiten_q[6:4], whiten_q[3] ^ whiten_q[0], whiten_q[2:1]};
                cnt_q    <= cnt_q + 11'd1;
                if (in_pdu) begin
                    oct_q <= {dbit, oct_q[6:1]};
                    crc_q <= crc_step;
                    if (cnt_q == 11'd15) len_q <= oct_q;
                end else begin
                    // CRC goes out MSB first; shifting left presents the next bit.
                    crc_q <= {crc_q[C-2:0], 1'b0};
                    if (dbit != crc_q[C-1]) crc_err_q <= 1'b1;
                    if (last_bit) begin
                        end_q    <= 1'b1;
                        crc_ok_q <= !crc_err_q && (dbit == crc_q[C-1]);
                        for (int k = 0; k < SAMPLE_PER_SYMBOL; k++) lane_q[k] <= '0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we) ram_q[cnt_q[8:3]] <= {dbit, oct_q};
    end

    assign pdu_octet_mem_data = ram_q[pdu_octet_mem_addr];
    assign hit_flag       = hit_q;
    assign decode_end     = end_q;
    assign crc_ok         = crc_ok_q;
    assign best_phase     = best_phase_q;
    assign payload_length = len_q;
endmodule

// File: tb/tb_btle_le1m_rx.sv
`timescale 1ns/1ps
module tb_btle_le1m_rx;
    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [31:0]        unique_bit_sequence = 32'h8E89BED6;
    logic [5:0]         channel_number = 6'd37;
    logic [23:0]        crc_state_init_bit = 24'h555555;
    logic signed [15:0] i_s = '0;
    logic signed [15:0] q_s = '0;
    logic               iq_valid = 1'b0;
    logic               hit_flag, decode_run, decode_end, crc_ok;
    logic [2:0]         best_phase;
    logic [6:0]         payload_length;
    logic [7:0]         mem_data;
    logic [5:0]         mem_addr = '0;

    btle_le1m_rx dut (
        .clk                 (clk),
        .rst                 (rst),
        .unique_bit_sequence (unique_bit_sequence),
        .channel_number      (channel_number),
        .crc_state_init_bit  (crc_state_init_bit),
        .i                   (i_s),
        .q                   (q_s),
        .iq_valid            (iq_valid),
        .hit_flag            (hit_flag),
        .decode_run          (decode_run),
        .decode_end          (decode_end),
        .crc_ok              (crc_ok),
        .best_phase          (best_phase),
        .payload_length      (payload_length),
        .pdu_octet_mem_data  (mem_data),
        .pdu_octet_mem_addr  (mem_addr)
    );

    always #5 clk = ~clk;

    typedef struct {
        int tx_ch;
        int rx_ch;
        int flip;
        bit aa_err;
        bit exp_hit;
        bit exp_crc;
        bit chk_len;
        bit chk_ram;
    } vec_t;

    int   checks = 0;
    int   failures = 0;
    int   hit_cnt = 0;
    int   end_cnt = 0;
    int   ph = 0;
    int   sample_idx = 0;
    int   exp_phase = 0;
    logic txbits[$];
    logic [7:0] pdu_tx [12];
    vec_t vecs [6];

    always @(negedge clk) begin
        if (hit_flag)   hit_cnt++;
        if (decode_end) end_cnt++;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: sim time limit reached, got no completion, required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic is_tap(input int k);
        return (k == 1) || (k == 3) || (k == 4) || (k == 6) || (k == 9) || (k == 10);
    endfunction

    task automatic emit();
        real th;
        th = 2.0 * 3.14159265358979 * real'(ph) / 32.0;
        @(negedge clk);
        i_s = 16'($rtoi(16000.0 * $cos(th)));
        q_s = 16'($rtoi(16000.0 * $sin(th)));
        iq_valid = 1'b1;
        sample_idx++;
        @(negedge clk);
        iq_valid = 1'b0;
    endtask

    // Over-air bit list: preamble, access address, whitened PDU and CRC.
    task automatic build_bits(input vec_t v);
        logic [31:0] aa;
        logic        c [24];
        logic        w [7];
        logic        data [$];
        logic        fb, b, w6;
        logic [5:0]  ch;
        txbits.delete();
        for (int k = 0; k < 8; k++) txbits.push_back(k[0]);
        aa = 32'h8E89BED6 ^ (v.aa_err ? 32'h0000_2000 : 32'h0);
        for (int k = 0; k < 32; k++) txbits.push_back(aa[k]);
        for (int k = 0; k < 24; k++) c[k] = crc_state_init_bit[k];
        for (int o = 0; o < 12; o++) begin
            for (int bi = 0; bi < 8; bi++) begin
                b  = pdu_tx[o][bi];
                fb = c[23] ^ b;
                for (int k = 23; k > 0; k--) c[k] = c[k-1] ^ (fb & is_tap(k));
                c[0] = fb;
                data.push_back(b ^ ((o * 8 + bi) == v.flip));
            end
        end
        for (int k = 23; k >= 0; k--) data.push_back(c[k]);
        ch = 6'(v.tx_ch);
        w[0] = 1'b1;
        for (int k = 1; k < 7; k++) w[k] = ch[6-k];
        for (int n = 0; n < data.size(); n++) begin
            txbits.push_back(data[n] ^ w[6]);
            w6 = w[6];
            for (int k = 6; k > 0; k--) w[k] = w[k-1];
            w[4] = w[4] ^ w6;
            w[0] = w6;
        end
    endtask

    // Ideal FSK: +/- pi/16 per sample; 3 idle samples give a timing offset.
    task automatic send_bits(input int nbits);
        repeat (3) emit();
        for (int n = 0; n < nbits; n++) begin
            for (int s = 0; s < 8; s++) begin
                ph = txbits[n] ? (ph + 1) % 32 : (ph + 31) % 32;
                if (n == 39 && s == 0) exp_phase = sample_idx % 8;
                emit();
            end
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int hb, eb, n;
        channel_number = 6'(v.rx_ch);
        build_bits(v);
        hb = hit_cnt;
        eb = end_cnt;
        send_bits(txbits.size());
        n = 0;
        while (v.exp_hit && end_cnt == eb && n < 9000) begin
            emit();
            n++;
        end
        repeat (16) emit();
        check($sformatf("v%0d hit_count", idx), hit_cnt - hb, int'(v.exp_hit));
        check($sformatf("v%0d decode_end_count", idx), end_cnt - eb, int'(v.exp_hit));
        check($sformatf("v%0d decode_run_after", idx), int'(decode_run), 0);
        if (v.exp_hit) begin
            check($sformatf("v%0d best_phase", idx), int'(best_phase), exp_phase);
            check($sformatf("v%0d crc_ok", idx), int'(crc_ok), int'(v.exp_crc));
        end
        if (v.chk_len) check($sformatf("v%0d payload_length", idx), int'(payload_length), 10);
        if (v.chk_ram) begin
            for (int k = 0; k < 12; k++) begin
                mem_addr = 6'(k);
                #1;
                check($sformatf("v%0d ram[%0d]", idx, k), int'(mem_data), int'(pdu_tx[k]));
            end
        end
    endtask

    initial begin
        int hb, eb;
        pdu_tx = '{8'h42, 8'h0A, 8'hD3, 8'h01, 8'hC0, 8'hFF,
                   8'hEE, 8'h33, 8'h5A, 8'hA5, 8'h00, 8'h7E};
        vecs[0] = '{37, 37, -1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        vecs[1] = '{37, 37, 20, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{37, 38, -1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
`ifdef BTLE_RX_AA_TOLERANCE_EN
        vecs[3] = '{37, 37, -1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
`else
        vecs[3] = '{37, 37, -1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
`endif
        vecs[4] = '{0, 0, -1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        vecs[5] = '{39, 39, 95, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

        // Reset state.
        repeat (2) @(negedge clk);
        check("reset hit_flag", int'(hit_flag), 0);
        check("reset decode_run", int'(decode_run), 0);
        check("reset decode_end", int'(decode_end), 0);
        check("reset crc_ok", int'(crc_ok), 0);
        check("reset best_phase", int'(best_phase), 0);
        check("reset payload_length", int'(payload_length), 0);
        rst = 1'b0;
        sample_idx = 0;
        hb = hit_cnt;
        repeat (100) @(negedge clk);
        check("idle no hit", hit_cnt - hb, 0);

        for (int k = 0; k < 6; k++) run_vec(vecs[k], k);

        // Reset in the middle of a decode.
        channel_number = 6'd37;
        build_bits(vecs[0]);
        hb = hit_cnt;
        eb = end_cnt;
        send_bits(64);
        check("midrst decode_run before", int'(decode_run), 1);
        check("midrst hit_count", hit_cnt - hb, 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst decode_run next clk", int'(decode_run), 0);
        rst = 1'b0;
        sample_idx = 0;
        check("midrst crc_ok", int'(crc_ok), 0);
        check("midrst payload_length", int'(payload_length), 0);
        check("midrst best_phase", int'(best_phase), 0);
        repeat (200) emit();
        check("midrst no decode_end", end_cnt - eb, 0);
        run_vec(vecs[0], 6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
